// File: rtl/lsu_align_ctrl_if.sv
// rtl/lsu_align_ctrl_if.sv - request/response and word-memory bus of the load/store alignment controller
interface lsu_align_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_data_in
  );
endinterface

// File: rtl/lsu_align_ctrl.sv
// rtl/lsu_align_ctrl.sv - splits byte-addressed RV32 loads/stores into word accesses with RMW stores
module lsu_align_ctrl #(
  parameter int unsigned MEM_WORDS = 2048
) (
  input  logic            clk,
  input  logic            rst,
  lsu_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;
  logic        err_q, err_d;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  // Range check on the incoming request, before anything is latched
  logic [31:0] req_w0, req_w1;
  logic        req_span, req_bad;

  always_comb begin
    req_w0   = {2'b00, bus.req_addr[31:2]};
    req_w1   = req_w0 + 32'd1;
    req_span = ({1'b0, bus.req_addr[1:0]} + size_bytes(bus.req_ctrl[1:0])) > 3'd4;
    req_bad  = (req_w0 >= 32'(MEM_WORDS)) || (req_span && (req_w1 >= 32'(MEM_WORDS)));
  end

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [31:0] w0, w1;
  logic        span;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  always_comb begin
    off      = addr_q[1:0];
    sh       = {off, 3'b000};
    w0       = {2'b00, addr_q[31:2]};
    w1       = w0 + 32'd1;
    span     = ({1'b0, off} + size_bytes(ctrl_q[1:0])) > 3'd4;
    mask8    = {4'b0000, size_mask(ctrl_q[1:0])} << off;
    wdata64  = {32'h0, wdata_q} << sh;
    rd_shift = 32'({buf1_q, buf0_q} >> sh);
    case (ctrl_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      buf0_q  <= 32'h0;
      buf1_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          ctrl_d  = bus.req_ctrl;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ACC0;
        end
      end
      ACC0: begin
        if (!we_q) buf0_d = bus.mem_data_out;
        state_d = span ? ACC1 : RESP;
      end
      ACC1: begin
        if (!we_q) buf1_d = bus.mem_data_out;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write enable is decoded from state alone so an async reset removes it at once
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = 32'h0;
    bus.resp_err    = 1'b0;
    bus.mem_addr    = 32'h0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_data_in = 32'h0;
    case (state_q)
      IDLE: bus.req_ready = 1'b1;
      ACC0: begin
        bus.mem_addr = w0;
        if (we_q) begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_data_in = merge(bus.mem_data_out, wdata64[31:0], mask8[3:0]);
        end
      end
      ACC1: begin
        bus.mem_addr = w1;
        if (we_q) begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_data_in = merge(bus.mem_data_out, wdata64[63:32], mask8[7:4]);
        end
      end
      default: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!we_q && !err_q) bus.resp_rdata = load_ext;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// tb/tb_lsu_align_ctrl.sv - scoreboard bench for lsu_align_ctrl against a word-addressed memory model
module tb_lsu_align_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_align_ctrl_if bus ();

  lsu_align_ctrl #(.MEM_WORDS(2048)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus.mem_data_out = (bus.mem_addr < 32'd2048) ? mem[bus.mem_addr[10:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_wr_en && bus.mem_addr < 32'd2048) mem[bus.mem_addr[10:0]] <= bus.mem_data_in;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wr);
    exp_t e;
    int   k;
    int   wr;
    bit   got;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.wr    = exp_wr;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    k   = 0;
    wr  = 0;
    got = 1'b0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      bus.req_valid = 1'b0;
      if (bus.mem_wr_en) wr++;
      if (k == 1 && !exp_err) chk({tag, " acc0_addr"}, bus.mem_addr, addr >> 2);
      if (bus.resp_valid) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " resp_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk({tag, " rdata"}, bus.resp_rdata, e.rdata);
      chk({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
      chk({tag, " latency"}, 32'(k), 32'(e.lat));
      chk({tag, " writes"}, 32'(wr), 32'(e.wr));
      @(negedge clk);
      chk({tag, " pulse"}, 32'(bus.resp_valid), 32'd0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_ctrl  = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    pl_en = 1'b1;
    pl_addr = 11'd0;    pl_data = 32'h11223344;
    @(negedge clk);
    pl_addr = 11'd1;    pl_data = 32'h55667788;
    @(negedge clk);
    pl_addr = 11'd2047; pl_data = 32'hCAFEF00D;
    @(negedge clk);
    pl_en = 1'b0;

    chk("rst ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_data_in", bus.mem_data_in, 32'h0);
    rst = 1'b0;

    do_req("lw0",    1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h11223344, 1'b0, 2, 0);
    do_req("lh3",    1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'hFFFF8811, 1'b0, 3, 0);
    do_req("lhu3",   1'b0, 3'b101, 32'h0000_0003, 32'h0, 32'h00008811, 1'b0, 3, 0);
    do_req("lb4",    1'b0, 3'b000, 32'h0000_0004, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0);
    do_req("lbu4",   1'b0, 3'b100, 32'h0000_0004, 32'h0, 32'h00000088, 1'b0, 2, 0);
    do_req("lh6",    1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'h00005566, 1'b0, 2, 0);
    do_req("lw1",    1'b0, 3'b010, 32'h0000_0001, 32'h0, 32'h88112233, 1'b0, 3, 0);

    do_req("sb5",    1'b1, 3'b000, 32'h0000_0005, 32'h000000AB, 32'h0, 1'b0, 2, 1);
    chk("sb5 word1", mem[1], 32'h5566AB88);
    chk("sb5 word0", mem[0], 32'h11223344);

    do_req("sw2",    1'b1, 3'b010, 32'h0000_0002, 32'hDEADBEEF, 32'h0, 1'b0, 3, 2);
    chk("sw2 word0", mem[0], 32'hBEEF3344);
    chk("sw2 word1", mem[1], 32'h5566DEAD);

    do_req("lw2000", 1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("sw1ffe", 1'b1, 3'b010, 32'h0000_1FFE, 32'h01020304, 32'h0, 1'b1, 1, 0);
    chk("sw1ffe word2047", mem[2047], 32'hCAFEF00D);
    do_req("lw1ffc", 1'b0, 3'b010, 32'h0000_1FFC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);

    // Abort a spanning store while its second word is being written
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_ctrl  = 3'b010;
    bus.req_addr  = 32'h0000_0002;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort acc0 we", 32'(bus.mem_wr_en), 32'd1);
    @(negedge clk);
    chk("abort acc1 we", 32'(bus.mem_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort async we", 32'(bus.mem_wr_en), 32'd0);
    chk("abort resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("abort no resp", 32'(bus.resp_valid), 32'd0);
    chk("abort word0", mem[0], 32'h56783344);
    chk("abort word1", mem[1], 32'h5566DEAD);
    do_req("lw4",    1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h5566DEAD, 1'b0, 2, 0);
    chk("sb empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
